tinysat_host: RTL and testbench
===============================

Name: tinysat_host

Overview:
- Host-side driver for the 4-variable, 16-clause 2-SAT solver tile. It is the master end of the solver's pin protocol (solver reset, run, load, 4-bit data in; x, sol, done out).
- Holds a 16-entry clause buffer written by the host. On `start` it pulses solver reset, streams the 48-cycle load sequence, asserts run until done or timeout, then captures and presents the result.
- Sits between the top-level host/config logic and the solver pins.

Parameters:
- NUM_BITS, 4, variable count; width of `sat_x` and `res_x`
- LOG2_NUM_CLAUSES, 4, clause index width; NUM_CLAUSES = 16
- TIMEOUT_CYCLES, 320, maximum run cycles before abandoning; must exceed 2^(NUM_BITS+LOG2_NUM_CLAUSES)+2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  clause buffer write strobe
- wr_addr  in  4  clause index
- wr_data  in  8  [3:0] literal 1, [7:4] literal 2; opaque 4-bit literal codes, passed through unmodified
- start  in  1  single-cycle start request
- abort  in  1  cancel the current operation
- busy  out  1  high in any state other than IDLE/DONE
- res_valid  out  1  result held valid
- res_sat  out  1  solver reported satisfiable
- res_timeout  out  1  run ended by timeout, not by done
- res_x  out  4  captured assignment
- sat_reset  out  1  to solver reset
- sat_run  out  1  to solver run
- sat_load  out  1  to solver load
- sat_data  out  4  to solver data
- sat_x  in  4  from solver
- sat_sol  in  1  from solver
- sat_done  in  1  from solver

Behaviour:
- Reset:
  - All `sat_*` outputs 0; `busy`, `res_*` 0.
  - Clause buffer cleared to 0x00.
  - State IDLE.
- All `sat_*` outputs are registered.
- Buffer writes:
  - Accepted only in IDLE or DONE; `wr_en` in other states is ignored.
  - A write in the same cycle as an accepted `start` is committed and used by that run.
- `start`:
  - Accepted in IDLE or DONE; ignored while busy.
  - On acceptance, `res_valid`, `res_sat`, `res_timeout` and `res_x` clear to 0 the following cycle.
- State machine: IDLE -> SRST -> LOAD -> RUN -> DONE.
  - SRST: exactly 1 cycle with `sat_reset`=1; all other `sat_*` = 0.
  - LOAD: `sat_load`=1 for exactly 48 consecutive cycles, k = 0..47. The solver's internal load counter advances once per load-high cycle: bank = k[5:4], address = k[3:0].
    - k 0..15: `sat_data` = 0 (pad bank, not stored by solver).
    - k 16..31: `sat_data` = buf[k-16][3:0].
    - k 32..47: `sat_data` = buf[k-32][7:4].
  - RUN:
    - Begins the cycle after the last load cycle; `sat_load`=0 and `sat_data`=0 throughout.
    - `sat_run` stays 1 while in RUN.
    - Run counter counts cycles in RUN from 0.
  - RUN exit on done: first cycle `sat_done`=1 is sampled.
    - Capture `res_x` <= `sat_x` and `res_sat` <= `sat_sol`; `res_timeout` <= 0.
    - `sat_run` drops to 0 next cycle; go to DONE.
  - RUN exit on timeout: run counter reaches TIMEOUT_CYCLES-1 with `sat_done`=0.
    - `res_timeout` <= 1; `res_sat` <= 0; `res_x` <= `sat_x`.
    - Go to DONE.
  - Done wins over timeout in the same cycle.
  - DONE: `res_valid`=1, `busy`=0. Hold results until the next accepted `start` or reset.
- `abort`:
  - In SRST, LOAD or RUN: next cycle return to IDLE, all `sat_*` = 0, `res_valid` stays 0.
  - In IDLE or DONE: no effect.
  - `abort` and `start` together in IDLE/DONE: `start` takes effect.
- `sat_done` or `sat_sol` activity outside RUN is ignored.
- Total latency, start to first `sat_run`=1: 1 (SRST) + 48 (LOAD) + 1 = 50 cycles after `start` is sampled.

Decomposition:
- Shared package `tinysat_pkg`:
  - NUM_BITS, LOG2_NUM_CLAUSES, NUM_CLAUSES.
  - Load bank constants BANK_PAD=0, BANK_LIT1=1, BANK_LIT2=2.
  - LOAD_CYCLES = 3*NUM_CLAUSES.
  - State enum.
- The solver tile is to be updated to import the same constants.
- One sub-module: `tinysat_clause_buf`, a 16x8 register file with synchronous write, asynchronous read, and synchronous clear on reset.

Test Plan:
- Load stream:
  - Stimulus: write buf[3]=0xA5, buf[15]=0x3C, others 0; pulse `start`.
  - Required response: `sat_reset`=1 one cycle; then `sat_load` high exactly 48 cycles; `sat_data`=5 at k=19, C at k=31, A at k=35, 3 at k=47, 0 at all other k.
- Normal completion:
  - Stimulus: behavioural solver model raises `sat_done` 100 cycles into RUN with `sat_x`=0x9, `sat_sol`=1.
  - Required response: `res_valid`=1, `res_sat`=1, `res_x`=0x9, `res_timeout`=0; `sat_run`=0 the cycle after capture.
- Timeout:
  - Stimulus: model never asserts `sat_done`.
  - Required response: after 320 RUN cycles `res_valid`=1, `res_timeout`=1, `res_sat`=0; `busy`=0.
- Abort:
  - Stimulus: `abort` at LOAD k=20.
  - Required response: next cycle `sat_load`=0, state IDLE, `res_valid`=0. A following `start` replays the full 48-cycle load from k=0.
- Blocked inputs:
  - Stimulus: `wr_en` (addr 0, data 0xFF) and a second `start` while in RUN.
  - Required response: both ignored; buf[0] unchanged; run completes normally.
- Reset mid-operation:
  - Stimulus: `reset` during RUN.
  - Required response: all outputs 0 next cycle; buffer reads 0x00; next run streams all-zero data.

Source files
------------

// File: rtl/tinysat_pkg.sv
// Shared constants for the tinysat solver tile and its host-side driver.
package tinysat_pkg;

    localparam int unsigned NUM_BITS         = 4;
    localparam int unsigned LOG2_NUM_CLAUSES = 4;
    localparam int unsigned NUM_CLAUSES      = 1 << LOG2_NUM_CLAUSES;
    localparam int unsigned LIT_W            = 4;
    localparam int unsigned CLAUSE_W         = 2 * LIT_W;

    // Load stream banks, selected by the upper bits of the load counter.
    localparam logic [1:0] BANK_PAD  = 2'd0;
    localparam logic [1:0] BANK_LIT1 = 2'd1;
    localparam logic [1:0] BANK_LIT2 = 2'd2;

    localparam int unsigned LOAD_CYCLES = 3 * NUM_CLAUSES;
    localparam int unsigned LOAD_CNT_W  = $clog2(LOAD_CYCLES);

    // Host FSM state encodings.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SRST = 3'd1;
    localparam state_t ST_LOAD = 3'd2;
    localparam state_t ST_RUN  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Literal nibble presented to the solver for a given bank and clause entry.
    function automatic logic [LIT_W-1:0] load_nibble(input logic [1:0]          bank,
                                                     input logic [CLAUSE_W-1:0] entry);
        case (bank)
            BANK_LIT1: return entry[LIT_W-1:0];
            BANK_LIT2: return entry[CLAUSE_W-1:LIT_W];
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/tinysat_clause_buf.sv
// 16 x 8 clause register file: synchronous write, asynchronous read, cleared on reset.
module tinysat_clause_buf
    import tinysat_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [LOG2_NUM_CLAUSES-1:0] wr_addr,
    input  logic [CLAUSE_W-1:0]         wr_data,
    input  logic [LOG2_NUM_CLAUSES-1:0] rd_addr,
    output logic [CLAUSE_W-1:0]         rd_data
);

    logic [CLAUSE_W-1:0] mem_q [NUM_CLAUSES];

    // Clear all entries on reset, otherwise commit the addressed write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/tinysat_host.sv
// Host-side master for the 2-SAT solver tile: buffers clauses, streams the
// load sequence, runs the solver with a timeout and presents the result.
module tinysat_host
    import tinysat_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 320
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [LOG2_NUM_CLAUSES-1:0] wr_addr,
    input  logic [CLAUSE_W-1:0]         wr_data,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        res_valid,
    output logic                        res_sat,
    output logic                        res_timeout,
    output logic [NUM_BITS-1:0]         res_x,
    output logic                        sat_reset,
    output logic                        sat_run,
    output logic                        sat_load,
    output logic [LIT_W-1:0]            sat_data,
    input  logic [NUM_BITS-1:0]         sat_x,
    input  logic                        sat_sol,
    input  logic                        sat_done
);

    localparam int unsigned RUN_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [RUN_CNT_W-1:0]  RUN_LAST  = RUN_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOAD_CNT_W-1:0] LOAD_LAST = LOAD_CNT_W'(LOAD_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [LOAD_CNT_W-1:0]   k_q, k_d;
    logic [RUN_CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic                    res_valid_q, res_valid_d;
    logic                    res_sat_q, res_sat_d;
    logic                    res_timeout_q, res_timeout_d;
    logic [NUM_BITS-1:0]     res_x_q, res_x_d;
    logic                    sat_reset_q, sat_reset_d;
    logic                    sat_run_q, sat_run_d;
    logic                    sat_load_q, sat_load_d;
    logic [LIT_W-1:0]        sat_data_q, sat_data_d;
    logic                    accepting;
    logic [CLAUSE_W-1:0]     rd_data;

    assign accepting = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Read address follows the next load index so sat_data can be registered.
    tinysat_clause_buf u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en && accepting),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (k_d[LOG2_NUM_CLAUSES-1:0]),
        .rd_data (rd_data)
    );

    // Next-state, result capture and registered pin values derived from the next state.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        run_cnt_d     = run_cnt_q;
        res_valid_d   = res_valid_q;
        res_sat_d     = res_sat_q;
        res_timeout_d = res_timeout_q;
        res_x_d       = res_x_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_SRST;
                    res_valid_d   = 1'b0;
                    res_sat_d     = 1'b0;
                    res_timeout_d = 1'b0;
                    res_x_d       = '0;
                end
            end
            ST_SRST: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (k_q == LOAD_LAST) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                end else begin
                    k_d = k_q + LOAD_CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sat_done) begin
                    state_d       = ST_DONE;
                    res_valid_d   = 1'b1;
                    res_sat_d     = sat_sol;
                    res_timeout_d = 1'b0;
                    res_x_d       = sat_x;
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d       = ST_DONE;
                    res_valid_d   = 1'b1;
                    res_sat_d     = 1'b0;
                    res_timeout_d = 1'b1;
                    res_x_d       = sat_x;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sat_reset_d = (state_d == ST_SRST);
        sat_load_d  = (state_d == ST_LOAD);
        sat_run_d   = (state_d == ST_RUN);
        sat_data_d  = '0;
        if (state_d == ST_LOAD) begin
            sat_data_d = load_nibble(k_d[LOG2_NUM_CLAUSES +: 2], rd_data);
        end
    end

    // State, counters, results and solver pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            run_cnt_q     <= '0;
            res_valid_q   <= 1'b0;
            res_sat_q     <= 1'b0;
            res_timeout_q <= 1'b0;
            res_x_q       <= '0;
            sat_reset_q   <= 1'b0;
            sat_run_q     <= 1'b0;
            sat_load_q    <= 1'b0;
            sat_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            run_cnt_q     <= run_cnt_d;
            res_valid_q   <= res_valid_d;
            res_sat_q     <= res_sat_d;
            res_timeout_q <= res_timeout_d;
            res_x_q       <= res_x_d;
            sat_reset_q   <= sat_reset_d;
            sat_run_q     <= sat_run_d;
            sat_load_q    <= sat_load_d;
            sat_data_q    <= sat_data_d;
        end
    end

    assign busy        = !accepting;
    assign res_valid   = res_valid_q;
    assign res_sat     = res_sat_q;
    assign res_timeout = res_timeout_q;
    assign res_x       = res_x_q;
    assign sat_reset   = sat_reset_q;
    assign sat_run     = sat_run_q;
    assign sat_load    = sat_load_q;
    assign sat_data    = sat_data_q;

endmodule

// File: tb/tb_tinysat_host.sv
// Self-checking bench for tinysat_host: timeline-based reference model,
// behavioural solver, directed scenarios and randomized runs.
module tb_tinysat_host;

    localparam int TO = 320;

    logic       clk = 1'b0;
    logic       reset, wr_en, start, abort;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy, res_valid, res_sat, res_timeout;
    logic [3:0] res_x;
    logic       sat_reset, sat_run, sat_load;
    logic [3:0] sat_data;
    logic [3:0] sat_x    = 4'd0;
    logic       sat_sol  = 1'b0;
    logic       sat_done = 1'b0;

    always #5 clk = ~clk;

    tinysat_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_sat     (res_sat),
        .res_timeout (res_timeout),
        .res_x       (res_x),
        .sat_reset   (sat_reset),
        .sat_run     (sat_run),
        .sat_load    (sat_load),
        .sat_data    (sat_data),
        .sat_x       (sat_x),
        .sat_sol     (sat_sol),
        .sat_done    (sat_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural solver ----------------
    int         done_after = -1;
    logic [3:0] sol_x      = 4'd0;
    logic       sol_sol    = 1'b0;
    bit         noise_en   = 1'b0;
    int         run_idx    = 0;
    bit         was_run    = 1'b0;

    always @(posedge clk) begin
        #1;
        if (sat_run === 1'b1) begin
            run_idx = was_run ? run_idx + 1 : 0;
            if (run_idx == done_after) begin
                sat_done = 1'b1;
                sat_x    = sol_x;
                sat_sol  = sol_sol;
            end else begin
                sat_done = 1'b0;
                sat_x    = 4'($urandom);
                sat_sol  = 1'($urandom);
            end
            was_run = 1'b1;
        end else begin
            was_run  = 1'b0;
            sat_done = noise_en ? 1'($urandom) : 1'b0;
            sat_sol  = 1'($urandom);
            sat_x    = 4'($urandom);
        end
    end

    // ---------------- reference model ----------------
    // Timeline view: t counts cycles since the accepted start
    // (t=1 solver reset, t=2..49 load index t-2, t>=50 run index t-50).
    bit         m_ok = 1'b0;
    bit         m_active = 1'b0;
    int         m_t = 0;
    bit         m_valid = 1'b0, m_sat = 1'b0, m_to = 1'b0;
    logic [3:0] m_x = 4'd0;
    logic [7:0] m_buf [16];

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_ok = 1'b1; m_active = 1'b0; m_t = 0;
            m_valid = 0; m_sat = 0; m_to = 0; m_x = 4'd0;
            for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
        end else if (!m_active) begin
            if (wr_en) m_buf[wr_addr] = wr_data;
            if (start) begin
                m_active = 1'b1; m_t = 1;
                m_valid = 0; m_sat = 0; m_to = 0; m_x = 4'd0;
            end
        end else if (abort) begin
            m_active = 1'b0;
        end else if (m_t >= 50) begin
            if (sat_done) begin
                m_active = 1'b0; m_valid = 1; m_sat = sat_sol; m_to = 0; m_x = sat_x;
            end else if (m_t - 50 == TO - 1) begin
                m_active = 1'b0; m_valid = 1; m_sat = 0; m_to = 1; m_x = sat_x;
            end else begin
                m_t++;
            end
        end else begin
            m_t++;
        end
    end

    function automatic logic [15:0] model_out();
        int         k;
        logic [3:0] d;
        logic [7:0] e;
        bit         ld;
        d  = 4'd0;
        ld = m_active && m_t >= 2 && m_t <= 49;
        if (ld) begin
            k = m_t - 2;
            if (k >= 32) begin
                e = m_buf[k - 32];
                d = e[7:4];
            end else if (k >= 16) begin
                e = m_buf[k - 16];
                d = e[3:0];
            end
        end
        return {m_active, m_valid, m_sat, m_to, m_x,
                m_active && m_t == 1, m_active && m_t >= 50, ld, d};
    endfunction

    function automatic logic [15:0] dut_out();
        return {busy, res_valid, res_sat, res_timeout, res_x,
                sat_reset, sat_run, sat_load, sat_data};
    endfunction

    always @(negedge clk) begin
        if (m_ok) check("cycle", {16'h0, dut_out()}, {16'h0, model_out()});
    end

    // ---------------- pin monitor ----------------
    logic [3:0] trace [4096];
    int load_n = 0, rst_n = 0, run_n = 0;

    always @(negedge clk) begin
        if (sat_load === 1'b1) begin
            if (load_n < 4096) trace[load_n] = sat_data;
            load_n++;
        end
        if (sat_reset === 1'b1) rst_n++;
        if (sat_run === 1'b1) run_n++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_buf(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // i counts cycles after the start edge: i=1 is the solver-reset cycle.
    task automatic do_run(input int abort_at, input int inject_at, input int reset_at, input bit noise);
        bit finished;
        start = 1'b1;
        if (noise) begin
            wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 8'($urandom);
            abort = 1'($urandom);
        end
        tick();
        start = 1'b0; wr_en = 1'b0; abort = 1'b0;
        finished = 1'b0;
        for (int i = 1; i <= 600 && !finished; i++) begin
            abort = (i == abort_at);
            reset = (i == reset_at);
            if (i == inject_at) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; start = 1'b1;
            end else if (noise) begin
                wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 8'($urandom);
                start = ($urandom_range(0, 3) == 0);
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            tick();
            if (busy !== 1'b1) finished = 1'b1;
        end
        abort = 1'b0; reset = 1'b0; wr_en = 1'b0; start = 1'b0;
        if (!finished) check("run_bound", 32'd0, 32'd1);
    endtask

    int lb, rb, sb, nz, mode, ab;
    logic [3:0] tv;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {16'h0, dut_out()}, 32'h0);
        reset = 1'b0;
        tick();

        // Load stream plus normal completion.
        write_buf(4'd3, 8'hA5);
        write_buf(4'd15, 8'h3C);
        done_after = 100; sol_x = 4'h9; sol_sol = 1'b1;
        lb = load_n; rb = rst_n; sb = run_n;
        do_run(-1, -1, -1, 1'b0);
        check("srst_cycles", rst_n - rb, 1);
        check("load_cycles", load_n - lb, 48);
        tv = trace[lb + 19]; check("data_k19", tv, 4'h5);
        tv = trace[lb + 31]; check("data_k31", tv, 4'hC);
        tv = trace[lb + 35]; check("data_k35", tv, 4'hA);
        tv = trace[lb + 47]; check("data_k47", tv, 4'h3);
        nz = 0;
        for (int k = 0; k < 48; k++)
            if (k != 19 && k != 31 && k != 35 && k != 47 && trace[lb + k] != 4'h0) nz++;
        check("data_other_zero", nz, 0);
        check("done_run_cycles", run_n - sb, 101);
        check("done_valid", res_valid, 1);
        check("done_sat", res_sat, 1);
        check("done_x", res_x, 4'h9);
        check("done_timeout", res_timeout, 0);
        check("done_run_low", sat_run, 0);

        // Timeout.
        done_after = -1;
        sb = run_n;
        do_run(-1, -1, -1, 1'b0);
        check("to_run_cycles", run_n - sb, TO);
        check("to_valid", res_valid, 1);
        check("to_flag", res_timeout, 1);
        check("to_sat", res_sat, 0);
        check("to_busy", busy, 0);

        // Abort at load index 20, then full replay.
        lb = load_n;
        do_run(22, -1, -1, 1'b0);
        check("abort_load_cycles", load_n - lb, 21);
        check("abort_load_low", sat_load, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        done_after = 5; sol_x = 4'h6; sol_sol = 1'b0;
        lb = load_n;
        do_run(-1, -1, -1, 1'b0);
        check("replay_load_cycles", load_n - lb, 48);
        tv = trace[lb + 19]; check("replay_k19", tv, 4'h5);
        check("replay_x", res_x, 4'h6);

        // Write and start while running are ignored.
        done_after = 30; sol_x = 4'h2; sol_sol = 1'b1;
        do_run(-1, 60, -1, 1'b0);
        check("blocked_valid", res_valid, 1);
        check("blocked_x", res_x, 4'h2);
        lb = load_n;
        do_run(-1, -1, -1, 1'b0);
        tv = trace[lb + 16]; check("blocked_buf0_lo", tv, 4'h0);
        tv = trace[lb + 32]; check("blocked_buf0_hi", tv, 4'h0);

        // Reset during RUN clears outputs and buffer.
        done_after = -1;
        do_run(-1, -1, 70, 1'b0);
        check("midreset_outputs", {16'h0, dut_out()}, 32'h0);
        done_after = 3;
        lb = load_n;
        do_run(-1, -1, -1, 1'b0);
        check("midreset_load_cycles", load_n - lb, 48);
        nz = 0;
        for (int k = 0; k < 48; k++) if (trace[lb + k] != 4'h0) nz++;
        check("midreset_zero_data", nz, 0);

        // Randomized runs.
        noise_en = 1'b1;
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(1, 4)) write_buf(4'($urandom), 8'($urandom));
            sol_x = 4'($urandom); sol_sol = 1'($urandom);
            mode = $urandom_range(0, 2);
            done_after = (mode == 1) ? -1 : $urandom_range(0, 200);
            ab = (mode == 2) ? $urandom_range(1, 120) : -1;
            do_run(ab, -1, -1, 1'b1);
            tick();
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
